bot_app_if: RTL and testbench

//  Application-CPU side of the Rojobot system-register interface. Snapshots the bot's
//  six 8-bit registers on each upd_sysregs rising edge and raises an interrupt to the

---
 rtl/bot_app_if.sv | 185 ++++++++++++++++++
 tb/tb_bot_app_if.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bot_app_if.sv
// Application-CPU side of the Rojobot register interface: snapshots bot registers, interrupts the CPU, serves kcpsm6 I/O.
// Optional MotCtl watchdog is enabled by defining MOTCTL_WDOG_EN.
module bot_app_if #(
    parameter logic [7:0]  BASE_ADDR   = 8'h00,
    parameter int unsigned WDOG_CYCLES = 2_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] LocX_in,
    input  logic [7:0] LocY_in,
    input  logic [7:0] Sensors_in,
    input  logic [7:0] BotInfo_in,
    input  logic [7:0] LMDist_in,
    input  logic [7:0] RMDist_in,
    input  logic       upd_sysregs,
    output logic [7:0] MotCtl_out,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt,
    input  logic       interrupt_ack
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        SVC  = 2'd2
    } state_t;

    state_t          state, state_next;
    logic            upd_d;
    logic [5:0][7:0] shadow;
    logic [5:0][7:0] staging;
    logic [5:0][7:0] live;
    logic            staged_valid, staged_next;
    logic [7:0]      overrun;
    logic            wdog_trip;
    logic [7:0]      addr_off;
    logic [7:0]      rd_data;
    logic            upd_event, wr_mot, wr_ctrl, release_req, clr_ovr;
    logic            load_live, load_staged, stage_live, ovr_inc;
    logic            unused;

    // Reads never have side effects, so the strobe is deliberately left unconsumed.
    assign unused = ^{read_strobe, WDOG_CYCLES[0]};

    assign live        = {RMDist_in, LMDist_in, BotInfo_in, Sensors_in, LocY_in, LocX_in};
    assign addr_off    = port_id - BASE_ADDR;
    assign upd_event   = upd_sysregs & ~upd_d;
    assign wr_mot      = write_strobe && (addr_off == 8'd8);
    assign wr_ctrl     = write_strobe && (addr_off == 8'd9);
    assign release_req = wr_ctrl & out_port[0];
    assign clr_ovr     = wr_ctrl & out_port[1];
    assign interrupt   = (state == PEND);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next  = state;
        staged_next = staged_valid;
        load_live   = 1'b0;
        load_staged = 1'b0;
        stage_live  = 1'b0;
        ovr_inc     = 1'b0;
        case (state)
            IDLE: begin
                if (upd_event) begin
                    load_live  = 1'b1;
                    state_next = PEND;
                end
            end
            PEND: begin
                if (upd_event) begin
                    stage_live  = 1'b1;
                    staged_next = 1'b1;
                    ovr_inc     = staged_valid;
                end
                if (interrupt_ack) state_next = SVC;
            end
            SVC: begin
                if (release_req) begin
                    if (staged_valid) begin
                        // Staged snapshot moves up; a coincident event refills staging without overrun.
                        load_staged = 1'b1;
                        state_next  = PEND;
                        if (upd_event) stage_live  = 1'b1;
                        else           staged_next = 1'b0;
                    end else if (upd_event) begin
                        load_live  = 1'b1;
                        state_next = PEND;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (upd_event) begin
                    stage_live  = 1'b1;
                    staged_next = 1'b1;
                    ovr_inc     = staged_valid;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: snapshot registers are reset too, so reads after reset return defined zeros.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            upd_d        <= 1'b0;
            shadow       <= '0;
            staging      <= '0;
            staged_valid <= 1'b0;
            overrun      <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            upd_d        <= upd_sysregs;
            staged_valid <= staged_next;
            if (load_live)   shadow  <= live;
            if (load_staged) shadow  <= staging;
            if (stage_live)  staging <= live;
            if (clr_ovr)                         overrun <= 8'h00;
            else if (ovr_inc && overrun != 8'hFF) overrun <= overrun + 8'd1;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (addr_off)
            8'd0:    rd_data = shadow[0];
            8'd1:    rd_data = shadow[1];
            8'd2:    rd_data = shadow[2];
            8'd3:    rd_data = shadow[3];
            8'd4:    rd_data = shadow[4];
            8'd5:    rd_data = shadow[5];
            8'd6:    rd_data = {3'b000, wdog_trip, staged_valid, 1'b0, state};
            8'd7:    rd_data = overrun;
            default: rd_data = 8'h00;
        endcase
    end

    // Registered read path gives the one-cycle latency kcpsm6 expects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) in_port <= 8'h00;
        else        in_port <= rd_data;
    end

`ifdef MOTCTL_WDOG_EN
    localparam int unsigned CW         = $clog2(WDOG_CYCLES + 1);
    localparam logic [CW-1:0] WDOG_MAX  = CW'(WDOG_CYCLES);
    localparam logic [CW-1:0] WDOG_LAST = CW'(WDOG_CYCLES - 1);

    logic [CW-1:0] wdog_cnt;

    // Counter parks at the limit so the stop command is issued once per silence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_cnt   <= '0;
            wdog_trip  <= 1'b0;
            MotCtl_out <= 8'h00;
        end else if (wr_mot) begin
            wdog_cnt   <= '0;
            wdog_trip  <= 1'b0;
            MotCtl_out <= out_port;
        end else if (wdog_cnt != WDOG_MAX) begin
            wdog_cnt <= wdog_cnt + 1'b1;
            if (wdog_cnt == WDOG_LAST) begin
                wdog_trip  <= 1'b1;
                MotCtl_out <= 8'h00;
            end
        end
    end
`else
    assign wdog_trip = 1'b0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      MotCtl_out <= 8'h00;
        else if (wr_mot) MotCtl_out <= out_port;
    end
`endif

endmodule

// File: tb/tb_bot_app_if.sv
// Scoreboard bench for bot_app_if: a transaction-level model predicts reads, interrupt and MotCtl.
// Define MOTCTL_WDOG_EN for both files to exercise the watchdog with a 16-cycle limit.
module tb_bot_app_if;

    localparam int W = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] LocX_in, LocY_in, Sensors_in, BotInfo_in, LMDist_in, RMDist_in;
    logic       upd_sysregs;
    logic [7:0] MotCtl_out;
    logic [7:0] port_id, out_port;
    logic       write_strobe, read_strobe;
    logic [7:0] in_port;
    logic       interrupt, interrupt_ack;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic       rd_d;

    // Model: snapshot held for the CPU, one staged snapshot, service phase 0/1/2.
    logic [7:0] m_shadow[6];
    logic [7:0] m_stage[6];
    bit         m_sv;
    int         m_state;
    int         m_ovr;
    logic [7:0] m_mot;
    bit         m_trip;
    int         m_wcnt;
    bit         m_upd_prev;

    bot_app_if #(.BASE_ADDR(8'h00), .WDOG_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .LocX_in(LocX_in), .LocY_in(LocY_in), .Sensors_in(Sensors_in),
        .BotInfo_in(BotInfo_in), .LMDist_in(LMDist_in), .RMDist_in(RMDist_in),
        .upd_sysregs(upd_sysregs), .MotCtl_out(MotCtl_out),
        .port_id(port_id), .out_port(out_port),
        .write_strobe(write_strobe), .read_strobe(read_strobe),
        .in_port(in_port), .interrupt(interrupt), .interrupt_ack(interrupt_ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: a read issued at one edge shows on in_port after it; compare at the next falling edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) rd_d <= 1'b0;
        else        rd_d <= read_strobe;
    end

    always @(negedge clk) begin
        if (rd_d) begin
            if (exp_q.size() == 0) check("rd_no_expect", in_port, 8'hxx);
            else                   check("in_port", in_port, exp_q.pop_front());
        end
    end

    function automatic logic [7:0] model_read(input logic [7:0] p);
        case (p)
            8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5: return m_shadow[p];
            8'd6: return {3'b000, m_trip, m_sv, 1'b0, 2'(m_state)};
            8'd7: return 8'(m_ovr);
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            m_shadow[i] = 8'h00;
            m_stage[i]  = 8'h00;
        end
        m_sv = 0; m_state = 0; m_ovr = 0; m_mot = 8'h00;
        m_trip = 0; m_wcnt = 0; m_upd_prev = 0;
        exp_q.delete();
    endtask

    // Release is applied first, then the event sees the resulting phase; this yields the coincident cases.
    task automatic model_step();
        logic [7:0] live[6];
        bit ev, rel, clr;
        int orig;
        live[0] = LocX_in; live[1] = LocY_in; live[2] = Sensors_in;
        live[3] = BotInfo_in; live[4] = LMDist_in; live[5] = RMDist_in;
        ev  = upd_sysregs && !m_upd_prev;
        m_upd_prev = upd_sysregs;
        rel = write_strobe && port_id == 8'd9 && out_port[0];
        clr = write_strobe && port_id == 8'd9 && out_port[1];
        orig = m_state;
        if (orig == 2 && rel) begin
            if (m_sv) begin
                m_shadow = m_stage;
                m_sv = 0;
                m_state = 1;
            end else begin
                m_state = 0;
            end
        end
        if (ev) begin
            if (m_state == 0) begin
                m_shadow = live;
                m_state = 1;
            end else begin
                if (m_sv) m_ovr = (m_ovr < 255) ? m_ovr + 1 : 255;
                m_stage = live;
                m_sv = 1;
            end
        end
        if (orig == 1 && interrupt_ack) m_state = 2;
        if (clr) m_ovr = 0;
        if (write_strobe && port_id == 8'd8) begin
            m_mot = out_port; m_wcnt = 0; m_trip = 0;
        end
`ifdef MOTCTL_WDOG_EN
        else if (m_wcnt < W) begin
            m_wcnt++;
            if (m_wcnt == W) begin
                m_mot = 8'h00;
                m_trip = 1;
            end
        end
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        if (read_strobe) exp_q.push_back(model_read(port_id));
        model_step();
        #1;
    endtask

    task automatic chk_irq();
        check("interrupt", {7'b0, interrupt}, {7'b0, m_state == 1});
    endtask

    task automatic chk_mot();
        check("MotCtl_out", MotCtl_out, m_mot);
    endtask

    task automatic rd(input logic [7:0] p);
        port_id = p; read_strobe = 1'b1;
        tick();
        read_strobe = 1'b0;
    endtask

    task automatic wr(input logic [7:0] p, input logic [7:0] d);
        port_id = p; out_port = d; write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic ack();
        interrupt_ack = 1'b1;
        tick();
        interrupt_ack = 1'b0;
        chk_irq();
    endtask

    task automatic pulse_evt(input logic [7:0] x);
        LocX_in = x;
        LocY_in = 8'($urandom); Sensors_in = 8'($urandom); BotInfo_in = 8'($urandom);
        LMDist_in = 8'($urandom); RMDist_in = 8'($urandom);
        upd_sysregs = 1'b1;
        tick();
        chk_irq();
        upd_sysregs = 1'b0;
        tick();
        chk_irq();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        #2;
        model_reset();
        check("rst_interrupt", {7'b0, interrupt}, 8'h00);
        check("rst_MotCtl", MotCtl_out, 8'h00);
        check("rst_in_port", in_port, 8'h00);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b0;
        {LocX_in, LocY_in, Sensors_in, BotInfo_in, LMDist_in, RMDist_in} = '0;
        upd_sysregs = 1'b0; port_id = 8'h00; out_port = 8'h00;
        write_strobe = 1'b0; read_strobe = 1'b0; interrupt_ack = 1'b0;
        model_reset();
        do_reset();
        rd(6); rd(0);

        // Snapshot and interrupt
        LocY_in = 8'h22;
        LocX_in = 8'h40;
        upd_sysregs = 1'b1;
        tick(); chk_irq();
        upd_sysregs = 1'b0;
        tick(); chk_irq();
        check("irq_after_event", {7'b0, interrupt}, 8'h01);
        rd(0); rd(1);

        // Acknowledge and release
        ack();
        rd(6);
        wr(9, 8'h01);
        rd(6); chk_irq();

        // Events during service stage without disturbing the snapshot
        pulse_evt(8'h40);
        ack();
        for (int v = 1; v <= 3; v++) pulse_evt(8'(v));
        rd(0); rd(7); rd(6);
        wr(9, 8'h01);
        chk_irq();
        rd(0); rd(6);

        // Release and event in the same cycle with a staged snapshot
        ack();
        pulse_evt(8'h11);
        LocX_in = 8'h22; upd_sysregs = 1'b1;
        port_id = 8'd9; out_port = 8'h01; write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0; upd_sysregs = 1'b0;
        tick(); chk_irq();
        rd(0); rd(6); rd(7);

        // Overrun clear beats a coincident increment
        LocX_in = 8'h5A; upd_sysregs = 1'b1;
        port_id = 8'd9; out_port = 8'h02; write_strobe = 1'b1;
        tick();
        write_strobe = 1'b0; upd_sysregs = 1'b0;
        tick();
        rd(7); rd(6);

        // Overrun saturation
        ack();
        for (int i = 0; i < 260; i++) pulse_evt(8'($urandom));
        rd(7);
        wr(9, 8'h02);
        rd(7);
        wr(3, 8'hFF);
        rd(3); rd(8); rd(9); rd(11);

        // MotCtl write, then reset while pending
        wr(8, 8'h33); chk_mot();
        wr(9, 8'h01); chk_irq();
        do_reset();
        rd(6); rd(0); rd(7);

        // MotCtl hold or watchdog
        wr(8, 8'h55); chk_mot();
        for (int i = 0; i < W + 4; i++) begin
            tick(); chk_mot();
        end
        rd(6);
        wr(8, 8'h77); chk_mot();
        rd(6);

        // Randomised traffic against the model
        for (int i = 0; i < 1500; i++) begin
            int act;
            LocX_in = 8'($urandom); LocY_in = 8'($urandom); Sensors_in = 8'($urandom);
            BotInfo_in = 8'($urandom); LMDist_in = 8'($urandom); RMDist_in = 8'($urandom);
            upd_sysregs   = ($urandom_range(0, 2) == 0);
            interrupt_ack = ($urandom_range(0, 3) == 0);
            read_strobe = 1'b0; write_strobe = 1'b0;
            act = $urandom_range(0, 9);
            if (act <= 3) begin
                port_id = 8'($urandom_range(0, 11)); read_strobe = 1'b1;
            end else if (act == 4) begin
                port_id = 8'd9; out_port = 8'($urandom_range(0, 3)); write_strobe = 1'b1;
            end else if (act == 5) begin
                port_id = 8'd8; out_port = 8'($urandom); write_strobe = 1'b1;
            end else if (act == 6) begin
                port_id = 8'($urandom_range(0, 7)); out_port = 8'($urandom); write_strobe = 1'b1;
            end
            tick();
            chk_irq(); chk_mot();
        end
        read_strobe = 1'b0; write_strobe = 1'b0; interrupt_ack = 1'b0; upd_sysregs = 1'b0;
        rd(6); rd(7);
        tick(); tick();
        check("queue_drained", 8'(exp_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
